// File: rtl/wt_dcache_reuse_pred_if.sv
`default_nettype none
// ============================================================================
// Module   : wt_dcache_reuse_pred_if
// Brief    : Query/training/flush bundle between miss unit and reuse predictor
// Revision : 1.0
// ============================================================================
interface wt_dcache_reuse_pred_if #(
  parameter int SIG_WIDTH = 6
);
  logic                 flush_i;
  logic                 query_valid_i;
  logic [SIG_WIDTH-1:0] query_sig_i;
  logic                 query_ready_o;
  logic                 pred_valid_o;
  logic [1:0]           pred_result_o;
  logic                 train_valid_i;
  logic [SIG_WIDTH-1:0] train_sig_i;
  logic                 train_reused_i;
  logic                 train_ready_o;
  logic                 busy_o;

  modport master (
    output flush_i, query_valid_i, query_sig_i,
    output train_valid_i, train_sig_i, train_reused_i,
    input  query_ready_o, pred_valid_o, pred_result_o, train_ready_o, busy_o
  );

  modport slave (
    input  flush_i, query_valid_i, query_sig_i,
    input  train_valid_i, train_sig_i, train_reused_i,
    output query_ready_o, pred_valid_o, pred_result_o, train_ready_o, busy_o
  );
endinterface
`default_nettype wire

// File: rtl/wt_dcache_reuse_pred.sv
`default_nettype none
// ============================================================================
// Module   : wt_dcache_reuse_pred
// Brief    : 2-bit saturating reuse predictor with training queue and flush sweep
// Revision : 1.0
// ============================================================================
module wt_dcache_reuse_pred #(
  parameter int         SIG_WIDTH   = 6,
  parameter int         TRAIN_DEPTH = 4,
  parameter logic [1:0] CTR_INIT    = 2'b10
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  wt_dcache_reuse_pred_if.slave bus
);
  localparam int                   c_num_entries = 2 ** SIG_WIDTH;
  localparam int                   c_ptr_w       = $clog2(TRAIN_DEPTH);
  localparam logic [SIG_WIDTH-1:0] c_last        = SIG_WIDTH'(c_num_entries - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } state_e;

  state_e                 r_state;
  logic [SIG_WIDTH-1:0]   r_sweep_ptr;
  logic [1:0]             r_ctr [c_num_entries];
  logic [SIG_WIDTH-1:0]   r_fifo_sig [TRAIN_DEPTH];
  logic [TRAIN_DEPTH-1:0] r_fifo_reused;
  logic [c_ptr_w:0]       r_wr_ptr;
  logic [c_ptr_w:0]       r_rd_ptr;
  logic                   r_pred_valid;
  logic [1:0]             r_pred_result;

  logic                 w_idle;
  logic                 w_fifo_empty;
  logic                 w_fifo_full;
  logic                 w_query_ready;
  logic                 w_train_ready;
  logic                 w_query_acc;
  logic                 w_push;
  logic                 w_pop;
  logic [SIG_WIDTH-1:0] w_pop_sig;
  logic                 w_pop_reused;
  logic [1:0]           w_pop_ctr;
  logic [1:0]           w_pop_next;

  assign w_idle        = (r_state == ST_IDLE);
  assign w_fifo_empty  = (r_wr_ptr == r_rd_ptr);
  assign w_fifo_full   = (r_wr_ptr[c_ptr_w] != r_rd_ptr[c_ptr_w]) &&
                         (r_wr_ptr[c_ptr_w-1:0] == r_rd_ptr[c_ptr_w-1:0]);
  assign w_query_ready = w_idle && !bus.flush_i;
  assign w_train_ready = w_query_ready && !w_fifo_full;
  assign w_query_acc   = bus.query_valid_i && w_query_ready;
  assign w_push        = bus.train_valid_i && w_train_ready;
  // Popping in the flush cycle is pointless: the sweep overwrites everything.
  assign w_pop         = w_idle && !bus.flush_i && !w_fifo_empty;
  assign w_pop_sig     = r_fifo_sig[r_rd_ptr[c_ptr_w-1:0]];
  assign w_pop_reused  = r_fifo_reused[r_rd_ptr[c_ptr_w-1:0]];
  assign w_pop_ctr     = r_ctr[w_pop_sig];

  always_comb begin
    w_pop_next = w_pop_ctr;
    if (w_pop_reused) begin
      if (w_pop_ctr != 2'b11) w_pop_next = w_pop_ctr + 2'b01;
    end else begin
      if (w_pop_ctr != 2'b00) w_pop_next = w_pop_ctr - 2'b01;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= ST_IDLE;
      r_sweep_ptr <= '0;
    end else if (bus.flush_i) begin
      r_state     <= ST_SWEEP;
      r_sweep_ptr <= '0;
    end else if (r_state == ST_SWEEP) begin
      r_sweep_ptr <= r_sweep_ptr + 1'b1;
      if (r_sweep_ptr == c_last) r_state <= ST_IDLE;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_fifo_reused <= '0;
      for (int i = 0; i < TRAIN_DEPTH; i++) r_fifo_sig[i] <= '0;
    end else if (bus.flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) begin
        r_fifo_sig[r_wr_ptr[c_ptr_w-1:0]]    <= bus.train_sig_i;
        r_fifo_reused[r_wr_ptr[c_ptr_w-1:0]] <= bus.train_reused_i;
        r_wr_ptr                             <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Reads the table before this edge's training write, giving pre-update values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_pred_valid  <= 1'b0;
      r_pred_result <= 2'b00;
    end else begin
      r_pred_valid <= w_query_acc;
      if (w_query_acc) r_pred_result <= r_ctr[bus.query_sig_i];
    end
  end

  for (genvar i = 0; i < c_num_entries; i++) begin : g_table
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        r_ctr[i] <= CTR_INIT;
      end else if ((r_state == ST_SWEEP) && (r_sweep_ptr == SIG_WIDTH'(i))) begin
        r_ctr[i] <= CTR_INIT;
      end else if (w_pop && (w_pop_sig == SIG_WIDTH'(i))) begin
        r_ctr[i] <= w_pop_next;
      end
    end
  end

  assign bus.query_ready_o = w_query_ready;
  assign bus.train_ready_o = w_train_ready;
  assign bus.pred_valid_o  = r_pred_valid;
  assign bus.pred_result_o = r_pred_result;
  assign bus.busy_o        = (r_state == ST_SWEEP);

endmodule
`default_nettype wire

// File: tb/tb_wt_dcache_reuse_pred.sv
`default_nettype none
// ============================================================================
// Module   : tb_wt_dcache_reuse_pred
// Brief    : Directed self-checking bench for wt_dcache_reuse_pred
// Revision : 1.0
// ============================================================================
module tb_wt_dcache_reuse_pred;
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  int   checks = 0;
  int   errors = 0;

  wt_dcache_reuse_pred_if #(.SIG_WIDTH(6)) u_if ();

  wt_dcache_reuse_pred #(
    .SIG_WIDTH  (6),
    .TRAIN_DEPTH(4),
    .CTR_INIT   (2'b10)
  ) u_dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .bus  (u_if)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic query_check(input string tag, input logic [5:0] sig, input logic [1:0] exp);
    u_if.query_valid_i = 1'b1;
    u_if.query_sig_i   = sig;
    step();
    u_if.query_valid_i = 1'b0;
    check({tag, "_valid"}, {7'd0, u_if.pred_valid_o}, 8'd1);
    check({tag, "_result"}, {6'd0, u_if.pred_result_o}, {6'd0, exp});
  endtask

  task automatic train(input logic [5:0] sig, input logic reused);
    int n = 0;
    u_if.train_valid_i  = 1'b1;
    u_if.train_sig_i    = sig;
    u_if.train_reused_i = reused;
    #1;
    while (!u_if.train_ready_o && n < 20) begin
      step();
      n++;
    end
    if (n >= 20) begin
      checks++;
      errors++;
      $display("FAIL train_wait: train_ready_o stayed low, required high");
    end
    step();
    u_if.train_valid_i = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       ready_bad;
    logic [1:0] pat [5];
    int         cnt;

    u_if.flush_i        = 1'b0;
    u_if.query_valid_i  = 1'b0;
    u_if.query_sig_i    = '0;
    u_if.train_valid_i  = 1'b0;
    u_if.train_sig_i    = '0;
    u_if.train_reused_i = 1'b0;

    // Reset values
    step();
    step();
    check("rst_pred_valid", {7'd0, u_if.pred_valid_o}, 8'd0);
    check("rst_pred_result", {6'd0, u_if.pred_result_o}, 8'd0);
    check("rst_busy", {7'd0, u_if.busy_o}, 8'd0);
    rst_i = 1'b0;
    #1;
    check("rst_query_ready", {7'd0, u_if.query_ready_o}, 8'd1);
    check("rst_train_ready", {7'd0, u_if.train_ready_o}, 8'd1);

    // First query returns CTR_INIT, pulse lasts one cycle, result held
    query_check("q5", 6'd5, 2'b10);
    check("q5_ready", {7'd0, u_if.query_ready_o}, 8'd1);
    step();
    check("q5_pulse_end", {7'd0, u_if.pred_valid_o}, 8'd0);
    check("q5_hold", {6'd0, u_if.pred_result_o}, 8'd2);

    // Saturate high then low
    for (int i = 0; i < 4; i++) train(6'd3, 1'b1);
    step();
    query_check("sat_hi", 6'd3, 2'b11);
    for (int i = 0; i < 5; i++) train(6'd3, 1'b0);
    step();
    query_check("sat_lo", 6'd3, 2'b00);

    // Held stream of five events on sig 10: 2 -1-> 1 +1-> 2 -1-> 1 -1-> 0 +1-> 1
    pat[0] = 2'd0; pat[1] = 2'd1; pat[2] = 2'd0; pat[3] = 2'd0; pat[4] = 2'd1;
    ready_bad = 1'b0;
    u_if.train_valid_i = 1'b1;
    u_if.train_sig_i   = 6'd10;
    for (int i = 0; i < 5; i++) begin
      u_if.train_reused_i = pat[i][0];
      #1;
      if (!u_if.train_ready_o) ready_bad = 1'b1;
      step();
    end
    u_if.train_valid_i = 1'b0;
    check("stream_ready", {7'd0, ready_bad}, 8'd0);
    step();
    query_check("stream_ctr", 6'd10, 2'b01);

    // Flush with a pending training entry on sig 3
    u_if.train_valid_i  = 1'b1;
    u_if.train_sig_i    = 6'd3;
    u_if.train_reused_i = 1'b1;
    step();
    u_if.train_valid_i = 1'b0;
    u_if.flush_i       = 1'b1;
    #1;
    check("flush_qready", {7'd0, u_if.query_ready_o}, 8'd0);
    check("flush_tready", {7'd0, u_if.train_ready_o}, 8'd0);
    step();
    u_if.flush_i = 1'b0;
    cnt = 0;
    ready_bad = 1'b0;
    while (u_if.busy_o && cnt < 200) begin
      cnt++;
      if (u_if.query_ready_o || u_if.train_ready_o) ready_bad = 1'b1;
      step();
    end
    check("sweep_len", cnt[7:0], 8'd64);
    check("sweep_ready_low", {7'd0, ready_bad}, 8'd0);
    query_check("post_flush3", 6'd3, 2'b10);
    step();
    query_check("post_flush3_again", 6'd3, 2'b10);
    query_check("post_flush10", 6'd10, 2'b10);

    // Query colliding with a training write returns the pre-update value
    train(6'd7, 1'b1);
    u_if.query_valid_i = 1'b1;
    u_if.query_sig_i   = 6'd7;
    step();
    check("collide_valid", {7'd0, u_if.pred_valid_o}, 8'd1);
    check("collide_pre", {6'd0, u_if.pred_result_o}, 8'd2);
    step();
    u_if.query_valid_i = 1'b0;
    check("b2b_valid", {7'd0, u_if.pred_valid_o}, 8'd1);
    check("b2b_post", {6'd0, u_if.pred_result_o}, 8'd3);
    step();
    check("b2b_end", {7'd0, u_if.pred_valid_o}, 8'd0);

    // Reset in the middle of a sweep
    train(6'd9, 1'b0);
    step();
    query_check("pre_rst9", 6'd9, 2'b01);
    u_if.flush_i = 1'b1;
    step();
    u_if.flush_i = 1'b0;
    for (int i = 0; i < 20; i++) step();
    check("mid_sweep_busy", {7'd0, u_if.busy_o}, 8'd1);
    rst_i = 1'b1;
    #1;
    check("async_busy", {7'd0, u_if.busy_o}, 8'd0);
    check("async_pred_valid", {7'd0, u_if.pred_valid_o}, 8'd0);
    check("async_pred_result", {6'd0, u_if.pred_result_o}, 8'd0);
    step();
    rst_i = 1'b0;
    #1;
    check("post_rst_busy", {7'd0, u_if.busy_o}, 8'd0);
    query_check("post_rst9", 6'd9, 2'b10);
    query_check("post_rst40", 6'd40, 2'b10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
